// File: rtl/opendap_link_state_monitor_pkg.sv
// rtl/opendap_link_state_monitor_pkg.sv - shared types and constants for the link state monitor
//
// Purpose: link_state encodings, the Dormant sub-FSM states, the selection
// alert LFSR seed/taps, the activation codes and the select-sequence words
// and lengths used by the SWD/JTAG matcher. All sequences are sent LSB first.
package opendap_link_state_monitor_pkg;

  typedef enum logic [1:0] {
    LINK_DORMANT = 2'd0,
    LINK_SWD     = 2'd1,
    LINK_JTAG    = 2'd2
  } link_state_e;

  typedef enum logic [1:0] {
    DS_HUNT  = 2'd0,
    DS_ALERT = 2'd1,
    DS_PAD   = 2'd2,
    DS_ACT   = 2'd3
  } dorm_state_e;

  // One flag per select sequence still consistent with the bits seen so far.
  typedef struct packed {
    logic s2d;
    logic s2j;
    logic j2d;
    logic j2s;
  } sel_mask_t;

  // Alert: bit 0 (a zero) is consumed while hunting; the remaining 127 bits
  // are the m-sequence of this LFSR, emitted from bit [0].
  localparam logic [6:0] ALERT_LFSR_INIT = 7'b1001001;
  localparam logic [6:0] ALERT_LFSR_TAPS = 7'b1001011;
  localparam logic [6:0] ALERT_LAST_IDX  = 7'd126;
  localparam logic [6:0] PAD_LAST_IDX    = 7'd3;

  localparam logic [7:0]  ACT_SWD_CODE  = 8'h1A;
  localparam logic [6:0]  ACT_SWD_LAST  = 7'd7;
  localparam logic [11:0] ACT_JTAG_CODE = 12'h000;
  localparam logic [6:0]  ACT_JTAG_LAST = 7'd11;

  localparam logic [15:0] SEL_S2D  = 16'hE3BC;
  localparam logic [15:0] SEL_S2J  = 16'hE73C;
  localparam logic [30:0] SEL_J2D  = 31'h33BBBBBA;
  localparam logic [15:0] SEL_J2S  = 16'hE79E;
  localparam logic [6:0]  SEL16_LAST = 7'd15;
  localparam logic [6:0]  SEL31_LAST = 7'd30;

  // Minimum run of highs that must precede JTAG-to-Dormant.
  localparam int JTAG_TO_DORMANT_RUN = 5;

endpackage

// File: rtl/opendap_link_state_monitor_if.sv
// rtl/opendap_link_state_monitor_if.sv - line-in / link-status bundle of the monitor
//
// Purpose: carries the snooped SWDIOTMS bit into the monitor and the link
// status back out.
// Signals:
//   swdi_reg      registered SWDIOTMS, one bit per swclk
//   link_state    current link (Dormant / SWD / JTAG)
//   exit_dormant  1-cycle pulse on Dormant -> SWD/JTAG
//   enter_dormant 1-cycle pulse on SWD/JTAG -> Dormant
//   protocol_sw   1-cycle pulse on legacy SWD <-> JTAG switch
//   line_reset    level, SWD line reset in progress
// Modports: master drives the line and watches status; slave is the monitor.
interface opendap_link_state_monitor_if;
  import opendap_link_state_monitor_pkg::*;

  logic        swdi_reg;
  link_state_e link_state;
  logic        exit_dormant;
  logic        enter_dormant;
  logic        protocol_sw;
  logic        line_reset;

  modport master (
    output swdi_reg,
    input  link_state, exit_dormant, enter_dormant, protocol_sw, line_reset
  );

  modport slave (
    input  swdi_reg,
    output link_state, exit_dormant, enter_dormant, protocol_sw, line_reset
  );

endinterface

// File: rtl/opendap_alert_lfsr.sv
// rtl/opendap_alert_lfsr.sv - 7-bit LFSR reproducing the selection alert body
//
// Purpose: generates alert bits 1..127 one per advance; resync reloads the
// seed so the first bit after resync is alert bit 1.
// Ports:
//   clk        probe clock
//   rst        asynchronous active-high reset (loads the seed)
//   resync_i   reload the seed (wins over advance_i)
//   advance_i  shift once: right shift, feedback into [6]
//   bit_o      expected alert bit for the current cycle
module opendap_alert_lfsr
  import opendap_link_state_monitor_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic resync_i,
  input  logic advance_i,
  output logic bit_o
);

  logic [6:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (resync_i) begin
      lfsr_d = ALERT_LFSR_INIT;
    end else if (advance_i) begin
      lfsr_d = {^(lfsr_q & ALERT_LFSR_TAPS), lfsr_q[6:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= ALERT_LFSR_INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/opendap_link_state_monitor.sv
// rtl/opendap_link_state_monitor.sv - Dormant/SWD/JTAG link state tracker for a multi-protocol debug port
//
// Purpose: snoops the registered SWDIOTMS line (one bit per swclk) and tracks
// the link state. In Dormant it hunts for preamble + selection alert + pad +
// activation code; in SWD/JTAG it matches the select sequences that leave the
// current protocol. All outputs are registered: the bit present before edge k
// is acted on at edge k.
// Ports:
//   swclk    probe clock, every posedge consumes one line bit
//   rst      asynchronous active-high reset
//   link_if  slave modport: swdi_reg in; link_state, exit_dormant,
//            enter_dormant, protocol_sw, line_reset out
module opendap_link_state_monitor
  import opendap_link_state_monitor_pkg::*;
#(
  parameter int LINE_RESET_CYCLES = 50,
  parameter int ALERT_PREAMBLE    = 8,
  parameter bit SUPPORT_JTAG      = 1'b1,
  parameter bit SUPPORT_LEGACY    = 1'b0,
  parameter int RESET_STATE       = 0
) (
  input  logic                        swclk,
  input  logic                        rst,
  opendap_link_state_monitor_if.slave link_if
);

  localparam int RW = $clog2(LINE_RESET_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(LINE_RESET_CYCLES);
  localparam logic [RW-1:0] RUN_PRE = RW'(ALERT_PREAMBLE);
  localparam logic [RW-1:0] RUN_JD  = RW'(JTAG_TO_DORMANT_RUN);
  localparam bit LEGACY_EN = SUPPORT_LEGACY && SUPPORT_JTAG;
  localparam link_state_e RESET_LINK = link_state_e'(RESET_STATE[1:0]);

  logic        din;
  link_state_e link_q, link_d;
  dorm_state_e dstate_q, dstate_d;
  logic [6:0]  bit_ctr_q, bit_ctr_d;
  logic [RW-1:0] run_q, run_d;
  sel_mask_t   mask_q, mask_d, hit;
  logic [1:0]  act_ok_q, act_ok_d;   // [1] JTAG code, [0] SWD code
  logic        swd_ok, jtag_ok;
  logic        ev_exit, ev_enter, ev_sw;
  logic        lfsr_load, lfsr_adv, lfsr_bit;
  logic        exit_q, exit_d;
  logic        enter_q, enter_d;
  logic        psw_q, psw_d;
  logic        lr_q, lr_d;

  assign din = link_if.swdi_reg;

  opendap_alert_lfsr u_alert_lfsr (
    .clk       (swclk),
    .rst       (rst),
    .resync_i  (lfsr_load),
    .advance_i (lfsr_adv),
    .bit_o     (lfsr_bit)
  );

  // State register
  always_ff @(posedge swclk or posedge rst) begin
    if (rst) begin
      link_q    <= RESET_LINK;
      dstate_q  <= DS_HUNT;
      bit_ctr_q <= '0;
      run_q     <= '0;
      mask_q    <= '0;
      act_ok_q  <= '0;
      exit_q    <= 1'b0;
      enter_q   <= 1'b0;
      psw_q     <= 1'b0;
      lr_q      <= 1'b0;
    end else begin
      link_q    <= link_d;
      dstate_q  <= dstate_d;
      bit_ctr_q <= bit_ctr_d;
      run_q     <= run_d;
      mask_q    <= mask_d;
      act_ok_q  <= act_ok_d;
      exit_q    <= exit_d;
      enter_q   <= enter_d;
      psw_q     <= psw_d;
      lr_q      <= lr_d;
    end
  end

  // Next-state logic
  always_comb begin
    link_d    = link_q;
    dstate_d  = dstate_q;
    bit_ctr_d = bit_ctr_q;
    mask_d    = mask_q;
    act_ok_d  = act_ok_q;
    hit       = '0;
    swd_ok    = 1'b0;
    jtag_ok   = 1'b0;
    ev_exit   = 1'b0;
    ev_enter  = 1'b0;
    ev_sw     = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    // Run of highs runs in every state, independent of any matching.
    if (din) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    end else begin
      run_d = '0;
    end

    case (link_q)
      LINK_DORMANT: begin
        case (dstate_q)
          DS_HUNT: begin
            // The zero ending the preamble is alert bit 0.
            if (!din && (run_q >= RUN_PRE)) begin
              dstate_d  = DS_ALERT;
              bit_ctr_d = ALERT_LAST_IDX;
              lfsr_load = 1'b1;
            end
          end
          DS_ALERT: begin
            lfsr_adv = 1'b1;
            if (din != lfsr_bit) begin
              dstate_d = DS_HUNT;
            end else if (bit_ctr_q == 7'd0) begin
              dstate_d  = DS_PAD;
              bit_ctr_d = PAD_LAST_IDX;
            end else begin
              bit_ctr_d = bit_ctr_q - 7'd1;
            end
          end
          DS_PAD: begin
            if (din) begin
              dstate_d = DS_HUNT;
            end else if (bit_ctr_q == 7'd0) begin
              dstate_d  = DS_ACT;
              bit_ctr_d = '0;
              act_ok_d  = {SUPPORT_JTAG, 1'b1};
            end else begin
              bit_ctr_d = bit_ctr_q - 7'd1;
            end
          end
          default: begin
            // DS_ACT: both activation codes are tracked in parallel.
            swd_ok  = act_ok_q[0] && (bit_ctr_q <= ACT_SWD_LAST) &&
                      (din == ACT_SWD_CODE[bit_ctr_q[2:0]]);
            jtag_ok = act_ok_q[1] && (bit_ctr_q <= ACT_JTAG_LAST) &&
                      (din == ACT_JTAG_CODE[bit_ctr_q[3:0]]);
            act_ok_d  = {jtag_ok, swd_ok};
            bit_ctr_d = bit_ctr_q + 7'd1;
            if (swd_ok && (bit_ctr_q == ACT_SWD_LAST)) begin
              link_d    = LINK_SWD;
              dstate_d  = DS_HUNT;
              bit_ctr_d = '0;
              mask_d    = '0;
              ev_exit   = 1'b1;
            end else if (jtag_ok && (bit_ctr_q == ACT_JTAG_LAST)) begin
              link_d    = LINK_JTAG;
              dstate_d  = DS_HUNT;
              bit_ctr_d = '0;
              mask_d    = '0;
              ev_exit   = 1'b1;
            end else if (!swd_ok && !jtag_ok) begin
              dstate_d = DS_HUNT;
            end
          end
        endcase
      end

      LINK_SWD, LINK_JTAG: begin
        if (mask_q == '0) begin
          // Idle: the first zero after a run is bit 0 of every select sequence.
          if (!din) begin
            mask_d.s2d = (link_q == LINK_SWD)  && (run_q == RUN_MAX);
            mask_d.s2j = LEGACY_EN && (link_q == LINK_SWD)  && (run_q == RUN_MAX);
            mask_d.j2d = (link_q == LINK_JTAG) && (run_q >= RUN_JD);
            mask_d.j2s = LEGACY_EN && (link_q == LINK_JTAG) && (run_q == RUN_MAX);
            bit_ctr_d  = 7'd1;
          end
        end else begin
          // 16-bit candidates finish at index 15, so the 4-bit index never wraps
          // while they are live.
          hit.s2d = mask_q.s2d && (din == SEL_S2D[bit_ctr_q[3:0]]);
          hit.s2j = mask_q.s2j && (din == SEL_S2J[bit_ctr_q[3:0]]);
          hit.j2d = mask_q.j2d && (din == SEL_J2D[bit_ctr_q[4:0]]);
          hit.j2s = mask_q.j2s && (din == SEL_J2S[bit_ctr_q[3:0]]);
          mask_d    = hit;
          bit_ctr_d = bit_ctr_q + 7'd1;
          if (hit.s2d && (bit_ctr_q == SEL16_LAST)) begin
            link_d   = LINK_DORMANT;
            dstate_d = DS_HUNT;
            mask_d   = '0;
            ev_enter = 1'b1;
          end else if (hit.s2j && (bit_ctr_q == SEL16_LAST)) begin
            link_d = LINK_JTAG;
            mask_d = '0;
            ev_sw  = 1'b1;
          end else if (hit.j2d && (bit_ctr_q == SEL31_LAST)) begin
            link_d   = LINK_DORMANT;
            dstate_d = DS_HUNT;
            mask_d   = '0;
            ev_enter = 1'b1;
          end else if (hit.j2s && (bit_ctr_q == SEL16_LAST)) begin
            link_d = LINK_SWD;
            mask_d = '0;
            ev_sw  = 1'b1;
          end
        end
      end

      default: begin
        // Encoding 3 is unreachable; fall back to a clean Dormant hunt.
        link_d   = LINK_DORMANT;
        dstate_d = DS_HUNT;
        mask_d   = '0;
      end
    endcase
  end

  // Output logic (registered in the state register)
  always_comb begin
    exit_d  = ev_exit;
    enter_d = ev_enter;
    psw_d   = ev_sw;
    lr_d    = (link_d == LINK_SWD) && (run_d == RUN_MAX);
  end

  assign link_if.link_state    = link_q;
  assign link_if.exit_dormant  = exit_q;
  assign link_if.enter_dormant = enter_q;
  assign link_if.protocol_sw   = psw_q;
  assign link_if.line_reset    = lr_q;

endmodule

// File: tb/tb_opendap_link_state_monitor.sv
// tb/tb_opendap_link_state_monitor.sv - directed self-checking bench for the link state monitor
module tb_opendap_link_state_monitor;

  localparam logic [127:0] ALERT = 128'h19BC0EA2_E3DDAFE9_86852D95_6209F392;
  localparam logic [127:0] S2D   = 128'hE3BC;
  localparam logic [127:0] S2J   = 128'hE73C;
  localparam logic [127:0] J2S   = 128'hE79E;
  localparam logic [127:0] J2D   = 128'h33BBBBBA;

  logic swclk;
  logic rst;
  logic line_bit;

  int checks;
  int failures;
  int exit_cnt [3];
  int enter_cnt [3];
  int psw_cnt [3];

  opendap_link_state_monitor_if if_def ();
  opendap_link_state_monitor_if if_nj ();
  opendap_link_state_monitor_if if_leg ();

  assign if_def.swdi_reg = line_bit;
  assign if_nj.swdi_reg  = line_bit;
  assign if_leg.swdi_reg = line_bit;

  opendap_link_state_monitor u_def (
    .swclk   (swclk),
    .rst     (rst),
    .link_if (if_def)
  );

  opendap_link_state_monitor #(.SUPPORT_JTAG(1'b0)) u_nj (
    .swclk   (swclk),
    .rst     (rst),
    .link_if (if_nj)
  );

  opendap_link_state_monitor #(.SUPPORT_LEGACY(1'b1)) u_leg (
    .swclk   (swclk),
    .rst     (rst),
    .link_if (if_leg)
  );

  initial swclk = 1'b0;
  always #5 swclk = ~swclk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      exit_cnt[i]  = 0;
      enter_cnt[i] = 0;
      psw_cnt[i]   = 0;
    end
  endtask

  task automatic send_bit(input logic b);
    line_bit = b;
    @(posedge swclk);
    #1;
    exit_cnt[0]  += int'(if_def.exit_dormant);
    exit_cnt[1]  += int'(if_nj.exit_dormant);
    exit_cnt[2]  += int'(if_leg.exit_dormant);
    enter_cnt[0] += int'(if_def.enter_dormant);
    enter_cnt[1] += int'(if_nj.enter_dormant);
    enter_cnt[2] += int'(if_leg.enter_dormant);
    psw_cnt[0]   += int'(if_def.protocol_sw);
    psw_cnt[1]   += int'(if_nj.protocol_sw);
    psw_cnt[2]   += int'(if_leg.protocol_sw);
  endtask

  task automatic send_bits(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic activate(input logic [127:0] code, input int n);
    send_ones(8);
    send_bits(ALERT, 128);
    send_zeros(4);
    send_bits(code, n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    line_bit = 1'b0;
    repeat (3) @(posedge swclk);
    #1 rst = 1'b0;
    clear_counts();
    checks++; if (if_def.link_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", if_def.link_state); end
    checks++; if (if_def.exit_dormant !== 1'b0) begin failures++; $display("FAIL reset_exit got=%b want=0", if_def.exit_dormant); end
    checks++; if (if_def.enter_dormant !== 1'b0) begin failures++; $display("FAIL reset_enter got=%b want=0", if_def.enter_dormant); end
    checks++; if (if_def.protocol_sw !== 1'b0) begin failures++; $display("FAIL reset_psw got=%b want=0", if_def.protocol_sw); end
    checks++; if (if_def.line_reset !== 1'b0) begin failures++; $display("FAIL reset_line_reset got=%b want=0", if_def.line_reset); end
    checks++; if (if_nj.link_state !== 2'd0) begin failures++; $display("FAIL reset_nj_state got=%0d want=0", if_nj.link_state); end
    checks++; if (if_leg.link_state !== 2'd0) begin failures++; $display("FAIL reset_leg_state got=%0d want=0", if_leg.link_state); end
  endtask

  task automatic test_swd_activate();
    clear_counts();
    activate(128'h1A, 8);
    checks++; if (if_def.exit_dormant !== 1'b1) begin failures++; $display("FAIL act_exit_pulse got=%b want=1", if_def.exit_dormant); end
    checks++; if (exit_cnt[0] !== 1) begin failures++; $display("FAIL act_exit_count got=%0d want=1", exit_cnt[0]); end
    checks++; if (if_def.link_state !== 2'd1) begin failures++; $display("FAIL act_state got=%0d want=1", if_def.link_state); end
    checks++; if (if_nj.link_state !== 2'd1) begin failures++; $display("FAIL act_nj_state got=%0d want=1", if_nj.link_state); end
    send_zeros(1);
    checks++; if (if_def.exit_dormant !== 1'b0) begin failures++; $display("FAIL act_pulse_width got=%b want=0", if_def.exit_dormant); end
    checks++; if (enter_cnt[0] + psw_cnt[0] !== 0) begin failures++; $display("FAIL act_other_pulses got=%0d want=0", enter_cnt[0] + psw_cnt[0]); end
  endtask

  task automatic test_line_reset();
    logic [127:0] v;
    clear_counts();
    send_ones(49);
    checks++; if (if_def.line_reset !== 1'b0) begin failures++; $display("FAIL lr_after49 got=%b want=0", if_def.line_reset); end
    send_ones(1);
    checks++; if (if_def.line_reset !== 1'b1) begin failures++; $display("FAIL lr_after50 got=%b want=1", if_def.line_reset); end
    send_ones(1);
    checks++; if (if_def.line_reset !== 1'b1) begin failures++; $display("FAIL lr_held got=%b want=1", if_def.line_reset); end
    checks++; if (if_nj.line_reset !== 1'b1) begin failures++; $display("FAIL lr_nj_held got=%b want=1", if_nj.line_reset); end
    send_bit(1'b0);
    checks++; if (if_def.line_reset !== 1'b0) begin failures++; $display("FAIL lr_drop got=%b want=0", if_def.line_reset); end
    checks++; if (if_def.link_state !== 2'd1) begin failures++; $display("FAIL lr_state_mid got=%0d want=1", if_def.link_state); end
    v = S2D >> 1;
    send_bits(v, 15);
    checks++; if (if_def.enter_dormant !== 1'b1) begin failures++; $display("FAIL s2d_pulse got=%b want=1", if_def.enter_dormant); end
    checks++; if (enter_cnt[0] !== 1) begin failures++; $display("FAIL s2d_count got=%0d want=1", enter_cnt[0]); end
    checks++; if (if_def.link_state !== 2'd0) begin failures++; $display("FAIL s2d_state got=%0d want=0", if_def.link_state); end
  endtask

  task automatic test_bad_alert();
    logic [127:0] v;
    clear_counts();
    v = ALERT;
    v[64] = ~v[64];
    send_ones(8);
    send_bits(v, 128);
    send_zeros(4);
    send_bits(128'h1A, 8);
    checks++; if (exit_cnt[0] !== 0) begin failures++; $display("FAIL bad_alert_exit got=%0d want=0", exit_cnt[0]); end
    checks++; if (if_def.link_state !== 2'd0) begin failures++; $display("FAIL bad_alert_state got=%0d want=0", if_def.link_state); end
    send_zeros(16);
    activate(128'h1A, 8);
    checks++; if (if_def.exit_dormant !== 1'b1) begin failures++; $display("FAIL retry_exit_pulse got=%b want=1", if_def.exit_dormant); end
    checks++; if (exit_cnt[0] !== 1) begin failures++; $display("FAIL retry_exit_count got=%0d want=1", exit_cnt[0]); end
    checks++; if (if_def.link_state !== 2'd1) begin failures++; $display("FAIL retry_state got=%0d want=1", if_def.link_state); end
  endtask

  task automatic test_short_run();
    clear_counts();
    send_ones(49);
    send_bits(S2D, 16);
    checks++; if (enter_cnt[0] !== 0) begin failures++; $display("FAIL short_run_enter got=%0d want=0", enter_cnt[0]); end
    checks++; if (if_def.link_state !== 2'd1) begin failures++; $display("FAIL short_run_state got=%0d want=1", if_def.link_state); end
    send_ones(50);
    send_bits(S2D, 16);
    checks++; if (enter_cnt[0] !== 1) begin failures++; $display("FAIL full_run_enter got=%0d want=1", enter_cnt[0]); end
    checks++; if (if_def.link_state !== 2'd0) begin failures++; $display("FAIL full_run_state got=%0d want=0", if_def.link_state); end
  endtask

  task automatic test_jtag();
    clear_counts();
    activate(128'h000, 12);
    checks++; if (if_def.exit_dormant !== 1'b1) begin failures++; $display("FAIL jact_pulse got=%b want=1", if_def.exit_dormant); end
    checks++; if (if_def.link_state !== 2'd2) begin failures++; $display("FAIL jact_state got=%0d want=2", if_def.link_state); end
    checks++; if (if_nj.link_state !== 2'd0) begin failures++; $display("FAIL nj_jact_state got=%0d want=0", if_nj.link_state); end
    checks++; if (exit_cnt[1] !== 0) begin failures++; $display("FAIL nj_jact_exit got=%0d want=0", exit_cnt[1]); end
    send_ones(4);
    send_bits(J2D, 31);
    checks++; if (enter_cnt[0] !== 0) begin failures++; $display("FAIL j2d_run4_enter got=%0d want=0", enter_cnt[0]); end
    checks++; if (if_def.link_state !== 2'd2) begin failures++; $display("FAIL j2d_run4_state got=%0d want=2", if_def.link_state); end
    send_ones(5);
    send_bits(J2D, 31);
    checks++; if (if_def.enter_dormant !== 1'b1) begin failures++; $display("FAIL j2d_pulse got=%b want=1", if_def.enter_dormant); end
    checks++; if (enter_cnt[0] !== 1) begin failures++; $display("FAIL j2d_count got=%0d want=1", enter_cnt[0]); end
    checks++; if (if_def.link_state !== 2'd0) begin failures++; $display("FAIL j2d_state got=%0d want=0", if_def.link_state); end
  endtask

  task automatic test_legacy();
    clear_counts();
    activate(128'h1A, 8);
    checks++; if (if_leg.link_state !== 2'd1) begin failures++; $display("FAIL leg_act_state got=%0d want=1", if_leg.link_state); end
    send_ones(50);
    send_bits(S2J, 16);
    checks++; if (if_leg.protocol_sw !== 1'b1) begin failures++; $display("FAIL s2j_pulse got=%b want=1", if_leg.protocol_sw); end
    checks++; if (if_leg.link_state !== 2'd2) begin failures++; $display("FAIL s2j_state got=%0d want=2", if_leg.link_state); end
    checks++; if (enter_cnt[2] !== 0) begin failures++; $display("FAIL s2j_enter got=%0d want=0", enter_cnt[2]); end
    checks++; if (if_def.link_state !== 2'd1) begin failures++; $display("FAIL s2j_def_state got=%0d want=1", if_def.link_state); end
    checks++; if (psw_cnt[0] !== 0) begin failures++; $display("FAIL s2j_def_psw got=%0d want=0", psw_cnt[0]); end
    send_ones(50);
    send_bits(J2S, 16);
    checks++; if (if_leg.link_state !== 2'd1) begin failures++; $display("FAIL j2s_state got=%0d want=1", if_leg.link_state); end
    checks++; if (psw_cnt[2] !== 2) begin failures++; $display("FAIL j2s_psw_count got=%0d want=2", psw_cnt[2]); end
    checks++; if (if_def.link_state !== 2'd1) begin failures++; $display("FAIL j2s_def_state got=%0d want=1", if_def.link_state); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] v;
    send_ones(30);
    #2 rst = 1'b1;
    @(posedge swclk);
    #1 rst = 1'b0;
    checks++; if (if_def.link_state !== 2'd0) begin failures++; $display("FAIL midrst_state got=%0d want=0", if_def.link_state); end
    checks++; if (if_leg.line_reset !== 1'b0) begin failures++; $display("FAIL midrst_lr got=%b want=0", if_leg.line_reset); end
    send_ones(8);
    send_bits(ALERT, 60);
    #2 rst = 1'b1;
    @(posedge swclk);
    #1 rst = 1'b0;
    clear_counts();
    v = ALERT >> 60;
    send_bits(v, 68);
    send_zeros(4);
    send_bits(128'h1A, 8);
    checks++; if (exit_cnt[0] !== 0) begin failures++; $display("FAIL partial_exit got=%0d want=0", exit_cnt[0]); end
    checks++; if (if_def.link_state !== 2'd0) begin failures++; $display("FAIL partial_state got=%0d want=0", if_def.link_state); end
    activate(128'h1A, 8);
    checks++; if (exit_cnt[0] !== 1) begin failures++; $display("FAIL b2b_exit got=%0d want=1", exit_cnt[0]); end
    checks++; if (if_def.link_state !== 2'd1) begin failures++; $display("FAIL b2b_state got=%0d want=1", if_def.link_state); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    line_bit = 1'b0;
    clear_counts();
    test_reset();
    test_swd_activate();
    test_line_reset();
    test_bad_alert();
    test_short_run();
    test_jtag();
    test_legacy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
